// File: rtl/riscv_fetch_aligner.sv
`default_nettype none
// =============================================================================
// riscv_fetch_aligner: extracts 16/32-bit instructions from 128-bit fetch lines,
// stitching line-straddling 32-bit instructions.            Revision: 1.0
// =============================================================================
module riscv_fetch_aligner #(
  parameter int LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  branch_i,
  input  logic [31:0]           branch_addr_i,
  input  logic                  ready_i,
  output logic                  valid_o,
  output logic [31:0]           rdata_o,
  output logic [31:0]           addr_o,
  output logic                  is_compressed_o,
  output logic                  prefetch_o,
  output logic [31:0]           prefetch_addr_o,
  output logic                  branch_o,
  output logic [31:0]           branch_addr_o,
  input  logic                  line_valid_i,
  input  logic [LINE_WIDTH-1:0] line_rdata_i,
  input  logic [31:0]           line_addr_i,
  output logic                  busy_o
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LINE = 2'd1,
    ALIGNED   = 2'd2,
    WAIT_NEXT = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [31:1]           pc_q, pc_d;
  logic [LINE_WIDTH-1:0] line_q, line_d;
  logic [27:0]           tag_q, tag_d;
  logic [15:0]           carry_q, carry_d;
  logic                  stitch_q, stitch_d;

  logic [2:0]             hw_idx;
  logic [LINE_WIDTH+15:0] line_ext;
  logic [31:0]            window;
  logic [27:0]            next_tag;
  logic [31:1]            pc_inc;
  logic                   straddle;
  logic                   unused_line_off;

  assign hw_idx   = pc_q[3:1];
  // Zero padding above the line lets the top halfword use the same 32-bit window.
  assign line_ext = {16'h0000, line_q};
  assign window   = line_ext[{1'b0, hw_idx, 4'b0000} +: 32];
  assign next_tag = pc_q[31:4] + 28'd1;
  assign straddle = !stitch_q && (hw_idx == 3'd7) && (line_q[113:112] == 2'b11);

  assign rdata_o         = stitch_q ? {line_q[15:0], carry_q} : window;
  assign addr_o          = {pc_q, 1'b0};
  assign is_compressed_o = (rdata_o[1:0] != 2'b11);
  assign pc_inc          = pc_q + (is_compressed_o ? 31'd1 : 31'd2);
  assign busy_o          = (state_q == WAIT_LINE) || (state_q == WAIT_NEXT);
  assign unused_line_off = ^line_addr_i[3:0];

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    line_d          = line_q;
    tag_d           = tag_q;
    carry_d         = carry_q;
    stitch_d        = stitch_q;
    valid_o         = 1'b0;
    prefetch_o      = 1'b0;
    prefetch_addr_o = {next_tag, 4'b0000};
    branch_o        = 1'b0;
    branch_addr_o   = branch_addr_i;

    if (branch_i) begin
      branch_o = 1'b1;
      pc_d     = branch_addr_i[31:1];
      stitch_d = 1'b0;
      state_d  = WAIT_LINE;
    end else begin
      case (state_q)
        WAIT_LINE: begin
          if (line_valid_i && (line_addr_i[31:4] == pc_q[31:4])) begin
            line_d  = line_rdata_i;
            tag_d   = line_addr_i[31:4];
            state_d = ALIGNED;
          end
        end
        WAIT_NEXT: begin
          if (line_valid_i && (line_addr_i[31:4] == next_tag)) begin
            line_d   = line_rdata_i;
            tag_d    = line_addr_i[31:4];
            stitch_d = 1'b1;
            state_d  = ALIGNED;
          end
        end
        ALIGNED: begin
          if (straddle) begin
            prefetch_o = 1'b1;
            carry_d    = line_q[127:112];
            state_d    = WAIT_NEXT;
          end else begin
            valid_o = 1'b1;
            if (ready_i) begin
              pc_d     = pc_inc;
              stitch_d = 1'b0;
              if (pc_inc[31:4] != tag_q) begin
                prefetch_o      = 1'b1;
                prefetch_addr_o = {pc_inc[31:4], 4'b0000};
                state_d         = WAIT_LINE;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      line_q   <= '0;
      tag_q    <= '0;
      carry_q  <= '0;
      stitch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      line_q   <= line_d;
      tag_q    <= tag_d;
      carry_q  <= carry_d;
      stitch_q <= stitch_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_riscv_fetch_aligner.sv
`default_nettype none
// =============================================================================
// tb_riscv_fetch_aligner: randomized L0/ID environment with an instruction-stream
// reference model plus directed scenarios.                   Revision: 1.0
// =============================================================================
module tb_riscv_fetch_aligner;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         branch_i = 1'b0;
  logic [31:0]  branch_addr_i = '0;
  logic         ready_i = 1'b0;
  logic         valid_o;
  logic [31:0]  rdata_o;
  logic [31:0]  addr_o;
  logic         is_compressed_o;
  logic         prefetch_o;
  logic [31:0]  prefetch_addr_o;
  logic         branch_o;
  logic [31:0]  branch_addr_o;
  logic         line_valid_i = 1'b0;
  logic [127:0] line_rdata_i = '0;
  logic [31:0]  line_addr_i = '0;
  logic         busy_o;

  riscv_fetch_aligner #(.LINE_WIDTH(128)) dut (
    .clk(clk), .rst(rst), .branch_i(branch_i), .branch_addr_i(branch_addr_i),
    .ready_i(ready_i), .valid_o(valid_o), .rdata_o(rdata_o), .addr_o(addr_o),
    .is_compressed_o(is_compressed_o), .prefetch_o(prefetch_o),
    .prefetch_addr_o(prefetch_addr_o), .branch_o(branch_o), .branch_addr_o(branch_addr_o),
    .line_valid_i(line_valid_i), .line_rdata_i(line_rdata_i), .line_addr_i(line_addr_i),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Instruction memory: hashed contents with per-address overrides for directed cases.
  logic [15:0] ov [logic [31:0]];
  logic [31:0] seed;

  function automatic logic [15:0] mem_hw(input logic [31:0] a);
    logic [31:0] x;
    if (ov.exists(a)) return ov[a];
    x = (a ^ seed) * 32'h9E3779B1;
    x = x ^ (x >> 15);
    return {x[15:2], x[20] ? 2'b11 : x[1:0]};
  endfunction

  function automatic logic [127:0] make_line(input logic [31:0] a);
    logic [127:0] l;
    logic [31:0]  base;
    base = {a[31:4], 4'b0000};
    for (int i = 0; i < 8; i++) l[16*i +: 16] = mem_hw(base + 32'(2 * i));
    return l;
  endfunction

  // L0 buffer model state
  logic        l0_auto = 1'b1;
  logic        stale_en = 1'b0;
  logic        line_present = 1'b0;
  logic [31:0] line_addr = '0;
  logic        pending = 1'b0;
  logic [31:0] req = '0;
  int          delay = 0;

  // Instruction-stream reference model
  logic        active = 1'b0;
  logic [31:0] exp_pc = '0;
  int          wait_cnt = 0;
  logic        hold = 1'b0;
  logic [31:0] hold_addr = '0;
  logic [31:0] hold_data = '0;

  // Observation counters for directed scenarios
  int          acc_cnt = 0;
  logic        pf_seen = 1'b0;
  logic [31:0] pf_addr = '0;
  logic [31:0] last_acc_addr = '0;
  logic [31:0] last_acc_data = '0;

  task automatic step(input logic br, input logic [31:0] ba, input logic rdy, input logic rs);
    logic [15:0] hw0, hw1;
    logic        exp_c;
    @(negedge clk);
    rst = rs; branch_i = br; branch_addr_i = ba; ready_i = rdy;
    line_valid_i = line_present; line_addr_i = line_addr; line_rdata_i = make_line(line_addr);
    #1;
    if (!rs) begin
      check("branch_o", branch_o, br);
      if (br) begin
        check("branch_addr_o", branch_addr_o, ba);
        check("valid_in_branch", valid_o, 0);
        check("prefetch_in_branch", prefetch_o, 0);
      end
      if (prefetch_o) begin
        check("prefetch_align", prefetch_addr_o[3:0], 0);
        pf_seen = 1'b1;
        pf_addr = prefetch_addr_o;
      end
      if (hold && !br) begin
        check("hold_valid", valid_o, 1);
        check("hold_addr", addr_o, hold_addr);
        check("hold_rdata", rdata_o, hold_data);
      end
      if (valid_o && !br) begin
        if (!active) check("valid_while_idle", valid_o, 0);
        else if (rdy) begin
          hw0   = mem_hw(exp_pc);
          hw1   = mem_hw(exp_pc + 32'd2);
          exp_c = (hw0[1:0] != 2'b11);
          check("addr", addr_o, exp_pc);
          check("compressed", is_compressed_o, exp_c);
          if (exp_c) check("rdata16", rdata_o[15:0], hw0);
          else       check("rdata32", rdata_o, {hw1, hw0});
          acc_cnt++;
          last_acc_addr = addr_o;
          last_acc_data = rdata_o;
          exp_pc   = exp_pc + (exp_c ? 32'd2 : 32'd4);
          wait_cnt = 0;
        end
      end
      hold      = !br && valid_o && !rdy;
      hold_addr = addr_o;
      hold_data = rdata_o;
      if (br) begin
        active   = 1'b1;
        exp_pc   = {ba[31:1], 1'b0};
        wait_cnt = 0;
      end else if (active && !(valid_o && rdy)) begin
        wait_cnt++;
        if (wait_cnt > 80) begin
          check("stall_cycles", wait_cnt, 0);
          wait_cnt = 0;
        end
      end
    end else begin
      active = 1'b0; hold = 1'b0; wait_cnt = 0;
    end
    if (l0_auto) begin
      if (rs) pending = 1'b0;
      else if (br) begin
        pending = 1'b1; req = {ba[31:4], 4'b0000}; delay = $urandom_range(0, 3);
      end else if (prefetch_o) begin
        pending = 1'b1; req = prefetch_addr_o; delay = $urandom_range(0, 3);
      end else if (pending) begin
        if (delay == 0) begin
          line_present = 1'b1; line_addr = req; pending = 1'b0;
        end else begin
          delay--;
          if (stale_en && $urandom_range(0, 1) == 1) begin
            line_present = 1'b1; line_addr = req + 32'h20;
          end
        end
      end
    end
  endtask

  task automatic do_reset();
    ov.delete();
    l0_auto = 1'b1; line_present = 1'b0; pending = 1'b0;
    step(1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic clear_obs();
    acc_cnt = 0; pf_seen = 1'b0;
  endtask

  task automatic run_until_pf(input int max, input logic rdy);
    for (int i = 0; i < max && !pf_seen; i++) step(1'b0, 32'h0, rdy, 1'b0);
    check("prefetch_seen", pf_seen, 1);
  endtask

  task automatic run_until_acc(input int target, input int max);
    for (int i = 0; i < max && acc_cnt < target; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    check("accept_count", acc_cnt, target);
  endtask

  logic [31:0] cap_addr, cap_data;
  logic [15:0] cap_hw;
  logic        need_br;
  logic        rbr, rrs;
  logic [31:0] rba;

  initial begin
    seed = $urandom;

    // Reset state
    do_reset();
    step(1'b0, 32'h0, 1'b0, 1'b0);
    check("rst_valid", valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_prefetch", prefetch_o, 0);

    // Eight compressed instructions from line 0x100
    for (int i = 0; i < 8; i++) ov[32'h100 + 32'(2 * i)] = 16'h4100 + 16'(i << 4);
    clear_obs();
    step(1'b1, 32'h100, 1'b1, 1'b0);
    check("t1_busy", busy_o, 0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check("t1_busy_wait", busy_o, 1);
    run_until_pf(40, 1'b1);
    check("t1_accepts", acc_cnt, 8);
    check("t1_pf_addr", pf_addr, 32'h110);

    // 32-bit instructions starting mid-line at 0x104
    do_reset();
    for (int i = 0; i < 8; i++) ov[32'h100 + 32'(2 * i)] = 16'h0013 + 16'(i << 8);
    clear_obs();
    step(1'b1, 32'h104, 1'b1, 1'b0);
    run_until_pf(40, 1'b1);
    check("t2_accepts", acc_cnt, 3);
    check("t2_last_addr", last_acc_addr, 32'h10C);
    check("t2_pf_addr", pf_addr, 32'h110);

    // Straddling instruction at 0x10E
    do_reset();
    ov[32'h10E] = 16'h1233; ov[32'h110] = 16'hABCD;
    clear_obs();
    step(1'b1, 32'h10E, 1'b1, 1'b0);
    run_until_pf(20, 1'b1);
    check("t3_no_early_accept", acc_cnt, 0);
    check("t3_pf_addr", pf_addr, 32'h110);
    run_until_acc(1, 30);
    check("t3_addr", last_acc_addr, 32'h10E);
    check("t3_rdata", last_acc_data, 32'hABCD1233);
    run_until_acc(2, 30);
    check("t3_next_addr", last_acc_addr, 32'h112);

    // Stall with ready low for five cycles
    do_reset();
    clear_obs();
    step(1'b1, 32'h180, 1'b0, 1'b0);
    for (int i = 0; i < 20 && !valid_o; i++) step(1'b0, 32'h0, 1'b0, 1'b0);
    check("t4_valid", valid_o, 1);
    cap_addr = addr_o; cap_data = rdata_o; cap_hw = mem_hw(cap_addr);
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b0, 1'b0);
    check("t4_addr_stable", addr_o, cap_addr);
    check("t4_rdata_stable", rdata_o, cap_data);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check("t4_one_accept", acc_cnt, 1);
    for (int i = 0; i < 20 && !valid_o; i++) step(1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    check("t4_pc_once", addr_o, cap_addr + ((cap_hw[1:0] != 2'b11) ? 32'd2 : 32'd4));

    // Branch while waiting for the second half, with a stale line present
    do_reset();
    ov[32'h10E] = 16'h1233;
    clear_obs();
    step(1'b1, 32'h10E, 1'b1, 1'b0);
    run_until_pf(20, 1'b1);
    l0_auto = 1'b0; line_present = 1'b1; line_addr = 32'h110;
    step(1'b1, 32'h200, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check("t5_valid_low", valid_o, 0);
    check("t5_busy", busy_o, 1);
    pending = 1'b1; req = 32'h200; delay = 0; l0_auto = 1'b1;
    run_until_acc(1, 30);
    check("t5_first_addr", last_acc_addr, 32'h200);

    // Reset during WAIT_LINE with a matching line present
    do_reset();
    l0_auto = 1'b0;
    step(1'b1, 32'h300, 1'b1, 1'b0);
    line_present = 1'b1; line_addr = 32'h300;
    step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check("t6_valid", valid_o, 0);
    check("t6_prefetch", prefetch_o, 0);
    check("t6_busy", busy_o, 0);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    check("t6_still_idle", valid_o, 0);

    // Randomized traffic, including redirects near the top of the address space
    do_reset();
    stale_en = 1'b1;
    need_br  = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      rbr = need_br || ($urandom_range(0, 39) == 0);
      rrs = !rbr && ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 3) == 0) rba = 32'hFFFF_FFC0 + 32'($urandom_range(0, 63));
      else                           rba = 32'h0000_1000 + 32'($urandom_range(0, 255));
      need_br = 1'b0;
      step(rbr, rba, ($urandom_range(0, 3) != 0), rrs);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/riscv_fetch_aligner.md
Name: riscv_fetch_aligner

Overview:
- Sits directly downstream of the 128-bit L0 instruction buffer and upstream of the ID stage.
- Holds one 128-bit fetch line and extracts 16-bit compressed or 32-bit instructions at halfword granularity.
- Stitches 32-bit instructions that straddle two lines, and issues branch and prefetch requests to the L0 buffer.

Parameters:
- LINE_WIDTH, 128, fetch line width in bits; only 128 is supported (4-bit line offset, 8 halfwords).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- branch_i  in  1  controller redirect request (pulse)
- branch_addr_i  in  32  redirect target; bit 0 ignored
- ready_i  in  1  ID stage accepts the current instruction
- valid_o  out  1  rdata_o/addr_o hold a valid instruction
- rdata_o  out  32  instruction; upper 16 bits are don't-care when compressed
- addr_o  out  32  PC of rdata_o
- is_compressed_o  out  1  rdata_o[1:0] != 2'b11
- prefetch_o  out  1  single-cycle line request to L0 (sequential)
- prefetch_addr_o  out  32  {next_line_tag, 4'b0000}
- branch_o  out  1  single-cycle redirect request to L0
- branch_addr_o  out  32  redirect address to L0
- line_valid_i  in  1  L0 line valid (level)
- line_rdata_i  in  128  L0 line data
- line_addr_i  in  32  address the L0 line was fetched for
- busy_o  out  1  waiting on a line

Behaviour:
- Registers:
  - pc_q[31:1]: halfword-aligned PC.
  - line_q[127:0]: captured line.
  - tag_q[27:0]: tag of line_q.
  - carry_q[15:0]: low half of a straddling instruction.
  - state.
- Reset (rst high at a clk edge):
  - state=IDLE, pc_q=0, line_q=0, carry_q=0.
  - valid_o=0, prefetch_o=0, branch_o=0, busy_o=0.
  - Reset mid-wait discards any pending line. A line_valid_i arriving after reset is ignored until a branch occurs.
- States: IDLE, WAIT_LINE, ALIGNED, WAIT_NEXT.
- Branch, highest priority in every state:
  - branch_i=1 drives branch_o=1 and branch_addr_o=branch_addr_i combinationally in the same cycle.
  - At the next edge: pc_q<=branch_addr_i[31:1], state<=WAIT_LINE.
  - valid_o is forced 0 in the branch cycle; an accept by the ID stage in that cycle is ignored.
  - branch_i together with line_valid_i: the line is dropped.
- IDLE: leaves only on branch_i.
- WAIT_LINE:
  - Captures the line when line_valid_i=1 and line_addr_i[31:4]==pc_q[31:4]: line_q<=line_rdata_i, tag_q<=line_addr_i[31:4], then go to ALIGNED.
  - A tag mismatch is ignored and the block stays in WAIT_LINE.
- ALIGNED, with h=pc_q[3:1]:
  - h<7: rdata_o=line_q[16h+31:16h], valid_o=1.
  - h==7 and line_q[113:112]!=2'b11: compressed, rdata_o={16'b0, line_q[127:112]}, valid_o=1.
  - h==7 and line_q[113:112]==2'b11: straddle.
    - valid_o=0, carry_q<=line_q[127:112].
    - prefetch_o=1 with prefetch_addr_o={pc_q[31:4]+1, 4'b0}.
    - Go to WAIT_NEXT.
  - Accept (valid_o & ready_i): pc_q += 1 halfword if compressed, else 2.
    - If the new pc_q[31:4] != tag_q, pulse prefetch_o for the new line in the same cycle and go to WAIT_LINE.
- WAIT_NEXT:
  - On a matching line_valid_i (tag == carry PC tag + 1): capture line, and present rdata_o={line_q[15:0], carry_q}, addr_o=pc_q, valid_o=1 in ALIGNED-with-carry.
  - On accept: pc_q += 2 halfwords (now h=1 in the new line), stay in ALIGNED.
- Output timing:
  - valid_o is registered-path: first valid at the edge after line capture. Latency from line_valid_i to valid_o is 1 cycle.
  - valid_o and rdata_o are held stable until accepted or branch.
- Address wrap: pc_q[31:4]+1 wraps modulo 2^28 (0xFFFFFFF0 -> 0x00000000).
- busy_o = state is WAIT_LINE or WAIT_NEXT.
- prefetch_o and branch_o are never high in the same cycle; branch wins.
- L0 line_valid_i stays high while L0 idles; a stale line is rejected by the tag check.

Test Plan:
- Branch to 0x100, L0 returns line 0x100 with eight 16-bit words all having [1:0]=00 → 8 compressed instructions at addr 0x100..0x10E, then prefetch_o with prefetch_addr_o=0x110.
- Branch to 0x104, line of 32-bit instructions (low bits 11), ready_i=1 every cycle → instructions at 0x104, 0x108, 0x10C, then prefetch_o to 0x110.
- Branch to 0x10E with line_q[113:112]=11 → prefetch_o to 0x110. Next line [15:0]=0xABCD, carry=0x1233 → rdata_o=0xABCD1233, addr_o=0x10E, next PC 0x112.
- ready_i=0 for 5 cycles with valid_o=1 → rdata_o and addr_o unchanged; PC advances exactly once when ready_i rises.
- branch_i to 0x200 while in WAIT_NEXT, with stale line_valid_i for tag 0x11 in the same and the following cycle → line ignored, branch_o=1 with branch_addr_o=0x200, valid_o low until line 0x200 arrives.
- rst asserted in WAIT_LINE while line_valid_i=1 → next cycle state IDLE, valid_o=0, prefetch_o=0; no capture.
